imm_materializer: RTL and testbench
===================================

Name: imm_materializer

Overview:
- Inverse of the decode-side immediate generator: takes a destination register and a 32-bit signed constant, and emits the RISC-V instruction sequence that loads that constant into the register.
- The sequence is LUI and/or ADDI(W), one instruction per valid/ready handshake.
- Used by the boot/self-test sequencer and the trap-stub generator to feed synthesized instructions into the fetch-bypass path.

Parameters:
- XLEN, 64: target register width. 64 selects ADDIW (opcode 7'h1B) for the low part; 32 selects ADDI (opcode 7'h13).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  block can accept a request
- req_rd_i  input  5  destination register index
- req_imm_i  input  32  constant, two's complement, sign-extended to XLEN by the emitted sequence
- inst_valid_o  output  1  inst_o holds a valid instruction
- inst_ready_i  input  1  consumer accepts inst_o
- inst_o  output  32  encoded instruction
- inst_last_o  output  1  inst_o is the final instruction of the current request
- busy_o  output  1  request in progress (state != IDLE)

Behaviour:
- Reset (async, immediate): state=IDLE; inst_valid_o=0, inst_o=32'h0, inst_last_o=0, busy_o=0; req_ready_o=1. Held request fields cleared. Reset mid-sequence abandons the request; no further instructions are emitted.
- Handshakes: a request is accepted when req_valid_i && req_ready_o. An instruction is consumed when inst_valid_o && inst_ready_i. req_ready_o = (state==IDLE), combinational from state. inst_o, inst_last_o and inst_valid_o are registered and stay stable while inst_valid_o && !inst_ready_i.
- Split, computed at acceptance and latched with rd:
  - hi20 = (req_imm_i + 32'h800)[31:12], 32-bit add, carry out discarded.
  - lo12 = req_imm_i[11:0].
- FSM states: IDLE, EMIT_LUI, EMIT_ADD.
  - IDLE, on accept:
    - hi20!=0 -> EMIT_LUI.
    - hi20==0 -> EMIT_ADD in x0 form (covers imm=0).
    - inst_valid_o rises the cycle after acceptance (latency 1).
  - EMIT_LUI: inst_o = {hi20, rd, 7'h37}.
    - inst_last_o=1 iff lo12==0.
    - On consume: last -> IDLE; else -> EMIT_ADD with inst_valid_o kept high (no bubble).
  - EMIT_ADD:
    - rs1=rd form (LUI was emitted): inst_o = {lo12, rd, 3'b000, rd, op}, op=7'h1B if XLEN==64, else 7'h13.
    - x0 form (no LUI): inst_o = {lo12, 5'd0, 3'b000, rd, 7'h13}.
    - inst_last_o=1. On consume -> IDLE; inst_valid_o falls the next cycle.
- A new request is not accepted in the same cycle as the last consume. req_ready_o returns the cycle after, so the minimum request period is N+1 cycles for N instructions.
- Wrap boundary: imm in 0x7FFFF800..0x7FFFFFFF gives hi20=0x80000 and negative lo12. ADDIW's 32-bit wrap plus sign extension yields the correct positive result; no special case.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- IMM_MAT_RDZERO_NOP_EN
  - Defined: a request with rd==0 emits exactly one canonical NOP, 32'h00000013, with inst_last_o=1, regardless of imm.
  - Undefined: rd==0 is encoded by the normal rules (one or two instructions targeting x0).

Test Plan:
- rd=5, imm=32'h12345678 -> 32'h123452B7 (last=0), then 32'h6782829B (last=1); no bubble between the two with inst_ready_i held at 1.
- rd=10, imm=32'hFFFFFFFF -> single 32'hFFF00513, last=1; req_ready_o high again 1 cycle after consume.
- rd=1, imm=32'h00001000 -> single LUI 32'h000010B7, last=1. rd=3, imm=0 -> single 32'h00000193, last=1 (macro undefined).
- rd=2, imm=32'h7FFFFFFF -> 32'h80000137, then 32'hFFF1011B (XLEN=64); with XLEN=32 the second is 32'hFFF10113.
- Backpressure: hold inst_ready_i=0 for 5 cycles during EMIT_LUI -> inst_o/inst_last_o stable, req_ready_o=0, a second req_valid_i ignored. Assert rst in EMIT_ADD -> inst_valid_o=0 and req_ready_o=1 immediately; no stale instruction emitted after release.
- With IMM_MAT_RDZERO_NOP_EN: rd=0, imm=32'h12345678 -> single 32'h00000013, last=1.

Source files
------------

// File: rtl/imm_materializer.sv
// ---------------------------------------------------------------------------
// imm_materializer
//   Turns a (rd, 32-bit signed constant) request into the RISC-V instruction
//   sequence that loads the constant: LUI and/or ADDI(W). It emits one
//   instruction per valid/ready handshake on the inst_* side.
//
// Parameters:
//   XLEN : 64 -> the low part uses ADDIW (7'h1B); 32 -> it uses ADDI (7'h13).
//
// Optional build macro:
//   IMM_MAT_RDZERO_NOP_EN : when defined, a request with rd==0 emits a single
//                           canonical NOP (32'h00000013).
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   req_valid_i     request valid
//   req_ready_o     block idle, can accept a request
//   req_rd_i        destination register index
//   req_imm_i       constant to materialize
//   inst_valid_o    inst_o holds a valid instruction
//   inst_ready_i    consumer accepts inst_o
//   inst_o          encoded instruction
//   inst_last_o     inst_o is the final instruction of the request
//   busy_o          request in progress
// ---------------------------------------------------------------------------
module imm_materializer #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_rd_i,
    input  logic [31:0] req_imm_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic        inst_last_o,
    output logic        busy_o
);

    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_ADDI = 7'h13;
    localparam logic [6:0] OP_LOW  = (XLEN == 64) ? 7'h1B : 7'h13;

    typedef enum logic [1:0] {S_IDLE, S_LUI, S_ADD} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_rd;
    logic [11:0] r_lo12;
    logic [31:0] r_inst, w_inst_nxt;
    logic        r_last, w_last_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_accept, w_consume, w_nop;
    logic [19:0] w_hi20;
    logic [11:0] w_lo12;

    assign w_accept  = req_valid_i && (r_state == S_IDLE);
    assign w_consume = r_valid && inst_ready_i;

    // (imm + 0x800)[31:12]: the +0x800 only carries into bit 12 when imm[11]
    // is set, so add that bit to the upper field instead of a full 32-bit add.
    assign w_hi20 = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
    assign w_lo12 = req_imm_i[11:0];

`ifdef IMM_MAT_RDZERO_NOP_EN
    assign w_nop = (req_rd_i == 5'd0);
`else
    assign w_nop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)
                        w_state_nxt = (w_nop || (w_hi20 == 20'd0)) ? S_ADD : S_LUI;
            S_LUI:  if (w_consume)
                        w_state_nxt = r_last ? S_IDLE : S_ADD;
            S_ADD:  if (w_consume)
                        w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: computes the next registered instruction. The first
    // instruction is built from the live request so it is valid one cycle
    // after acceptance; the ADDIW follow-up is built from the latched fields.
    always_comb begin
        w_inst_nxt  = r_inst;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        unique case (r_state)
            S_IDLE: if (w_accept) begin
                w_valid_nxt = 1'b1;
                if (w_nop) begin
                    w_inst_nxt = 32'h0000_0013;
                    w_last_nxt = 1'b1;
                end else if (w_hi20 != 20'd0) begin
                    w_inst_nxt = {w_hi20, req_rd_i, OP_LUI};
                    w_last_nxt = (w_lo12 == 12'd0);
                end else begin
                    // x0 form: always ADDI, the value already fits in 12 bits
                    w_inst_nxt = {w_lo12, 5'd0, 3'b000, req_rd_i, OP_ADDI};
                    w_last_nxt = 1'b1;
                end
            end
            S_LUI: if (w_consume) begin
                if (r_last) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    // valid stays high: no bubble between LUI and ADD
                    w_inst_nxt = {r_lo12, r_rd, 3'b000, r_rd, OP_LOW};
                    w_last_nxt = 1'b1;
                end
            end
            S_ADD: if (w_consume) w_valid_nxt = 1'b0;
            default: ;
        endcase
    end

    // Held request fields and registered instruction outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= 5'd0;
            r_lo12  <= 12'd0;
            r_inst  <= 32'd0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd   <= req_rd_i;
                r_lo12 <= w_lo12;
            end
            r_inst  <= w_inst_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign inst_valid_o = r_valid;
    assign inst_o       = r_inst;
    assign inst_last_o  = r_last;

endmodule

// File: tb/tb_imm_materializer.sv
module tb_imm_materializer;
    localparam int XLEN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o;
    logic [4:0]  req_rd_i;
    logic [31:0] req_imm_i;
    logic        inst_valid_o, inst_ready_i, inst_last_o, busy_o;
    logic [31:0] inst_o;

    int ncmp  = 0;
    int nfail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    imm_materializer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rd_i(req_rd_i), .req_imm_i(req_imm_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_last_o(inst_last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: split imm into a signed low 12 bits and the remaining upper
    // part (imm - lo) >> 12, then pick the shortest LUI/ADDI(W) sequence.
    function automatic void model(input logic [4:0] rd, input logic [31:0] imm);
        logic signed [11:0] l12;
        int                 lo;
        logic [31:0]        d;
        logic [19:0]        hi;
        logic [6:0]         lowop;
        l12   = imm[11:0];
        lo    = l12;
        d     = imm - lo;
        hi    = d[31:12];
        lowop = (XLEN == 64) ? 7'h1B : 7'h13;
        exp_q.delete();
`ifdef IMM_MAT_RDZERO_NOP_EN
        if (rd == 5'd0) begin
            exp_q.push_back(32'h0000_0013);
            return;
        end
`endif
        if (hi != 20'd0) begin
            exp_q.push_back({hi, rd, 7'h37});
            if (lo != 0) exp_q.push_back({imm[11:0], rd, 3'b000, rd, lowop});
        end else begin
            exp_q.push_back({imm[11:0], 5'd0, 3'b000, rd, 7'h13});
        end
    endfunction

    // Architectural execution of the observed sequence on one register.
    function automatic longint exec_obs();
        longint             r = 0;
        longint             src;
        logic signed [31:0] t;
        logic signed [11:0] i12;
        logic [63:0]        s;
        foreach (obs_q[k]) begin
            i12 = obs_q[k][31:20];
            src = (obs_q[k][19:15] == 5'd0) ? 64'sd0 : r;
            case (obs_q[k][6:0])
                7'h37: begin t = {obs_q[k][31:12], 12'h000}; r = t; end
                7'h13: r = src + i12;
                7'h1B: begin s = src + i12; t = s[31:0]; r = t; end
                default: r = 64'hDEAD;
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [4:0] rd, input logic [31:0] imm);
        int n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1;
        req_rd_i    = rd;
        req_imm_i   = imm;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Drain the current sequence against exp_q; valid must never drop
    // mid-sequence and outputs must hold while stalled.
    task automatic collect(input string tag, input bit rnd);
        int idx = 0;
        int cyc = 0;
        obs_q.delete();
        while (idx < exp_q.size() && cyc < 200) begin
            chk({tag, "_valid"}, {63'd0, inst_valid_o}, 64'd1);
            chk({tag, "_inst"},  {32'd0, inst_o}, {32'd0, exp_q[idx]});
            chk({tag, "_last"},  {63'd0, inst_last_o}, {63'd0, (idx == exp_q.size() - 1)});
            chk({tag, "_rdy_lo"}, {63'd0, req_ready_o}, 64'd0);
            chk({tag, "_busy"},  {63'd0, busy_o}, 64'd1);
            inst_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inst_ready_i) begin
                obs_q.push_back(inst_o);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        inst_ready_i = 1'b0;
        chk({tag, "_count"},   idx, exp_q.size());
        chk({tag, "_vld_end"}, {63'd0, inst_valid_o}, 64'd0);
        chk({tag, "_rdy_end"}, {63'd0, req_ready_o}, 64'd1);
        chk({tag, "_bsy_end"}, {63'd0, busy_o}, 64'd0);
    endtask

    task automatic check_value(input string tag, input logic [4:0] rd, input logic [31:0] imm);
        logic signed [31:0] si;
        longint             e, r;
        si = imm;
        e  = si;
        r  = exec_obs();
        if (rd != 5'd0) begin
            if (XLEN == 32) chk({tag, "_value"}, {32'd0, r[31:0]}, {32'd0, e[31:0]});
            else            chk({tag, "_value"}, r, e);
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [4:0]  rd;
        logic [31:0] imm;
        rst = 1'b1; req_valid_i = 1'b0; req_rd_i = '0; req_imm_i = '0; inst_ready_i = 1'b0;
        #1;
        chk("rst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("rst_inst",  {32'd0, inst_o}, 64'd0);
        chk("rst_last",  {63'd0, inst_last_o}, 64'd0);
        chk("rst_busy",  {63'd0, busy_o}, 64'd0);
        chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        exp_q = '{32'h123452B7, 32'h6782829B};
        send(5'd5, 32'h12345678); collect("d_lui_add", 1'b0); check_value("d_lui_add", 5'd5, 32'h12345678);
        exp_q = '{32'hFFF00513};
        send(5'd10, 32'hFFFFFFFF); collect("d_neg1", 1'b0);
        exp_q = '{32'h000010B7};
        send(5'd1, 32'h00001000); collect("d_lui_only", 1'b0);
        exp_q = '{32'h00000193};
        send(5'd3, 32'h0); collect("d_zero", 1'b0);
        exp_q = '{32'h80000137, (XLEN == 64) ? 32'hFFF1011B : 32'hFFF10113};
        send(5'd2, 32'h7FFFFFFF); collect("d_wrap", 1'b0); check_value("d_wrap", 5'd2, 32'h7FFFFFFF);
`ifdef IMM_MAT_RDZERO_NOP_EN
        exp_q = '{32'h00000013};
`else
        model(5'd0, 32'h12345678);
`endif
        send(5'd0, 32'h12345678); collect("d_rd0", 1'b0);

        // Backpressure in EMIT_LUI with a competing request that must be ignored
        send(5'd5, 32'h12345678);
        req_valid_i = 1'b1; req_rd_i = 5'd7; req_imm_i = 32'h00ABC123;
        for (int i = 0; i < 5; i++) begin
            chk("bp_inst",  {32'd0, inst_o}, 64'h123452B7);
            chk("bp_last",  {63'd0, inst_last_o}, 64'd0);
            chk("bp_valid", {63'd0, inst_valid_o}, 64'd1);
            chk("bp_ready", {63'd0, req_ready_o}, 64'd0);
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        exp_q = '{32'h123452B7, 32'h6782829B};
        collect("bp", 1'b0);
        @(negedge clk);
        chk("bp_no_extra", {63'd0, inst_valid_o}, 64'd0);

        // Reset while in EMIT_ADD
        send(5'd5, 32'h12345678);
        inst_ready_i = 1'b1;
        @(negedge clk);
        inst_ready_i = 1'b0;
        chk("pre_rst_inst", {32'd0, inst_o}, 64'h6782829B);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("mid_rst_busy",  {63'd0, busy_o}, 64'd0);
        chk("mid_rst_inst",  {32'd0, inst_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {63'd0, inst_valid_o}, 64'd0);
        end
        inst_ready_i = 1'b0;

        // Randomized requests with random consumer stalls
        for (int n = 0; n < 40; n++) begin
            rd = 5'($urandom_range(0, 31));
            rv = $urandom;
            case ($urandom_range(0, 3))
                0: imm = rv;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = 32'h7FFFF800 + 32'($urandom_range(0, 2047));
                default: imm = {rv[19:0], 12'h000};
            endcase
            model(rd, imm);
            send(rd, imm);
            collect("rnd", 1'b1);
            check_value("rnd", rd, imm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
